// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: widths, opcodes, flag layout.
package alu_pkg;

    localparam int unsigned BITS   = 16;
    localparam int unsigned REGS   = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned FLAG_W = 5;

    // Bit positions inside the packed {V,C,N,P,Z} flag vector
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_P = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 4;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpAnd = 3'd3,
        OpOr  = 3'd4,
        OpXor = 3'd5,
        OpShf = 3'd6,
        OpRot = 3'd7
    } OperationType;

    // Only MUL (high half) and SHF (spilled bits) produce a value worth keeping in HI
    function automatic logic op_writes_hi(input OperationType op);
        return (op == OpMul) || (op == OpShf);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: REGS x BITS, two operand reads with write-first bypass, one debug read,
// one write port. r0 always reads zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [BITS-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [BITS-1:0]   o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [BITS-1:0]   o_rdata_b,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [BITS-1:0]   o_dbg_data
);

    logic [BITS-1:0] r_regs [REGS];
    logic            w_we;

    assign w_we = i_we && (i_waddr != '0);

    // Storage: cleared on reset, single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Operand reads: a same-cycle write to the addressed register wins over stored data
    always_comb begin
        o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
        o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
        if (w_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
        if (w_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
    end

    // Debug read shows committed state only
    always_comb begin
        o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue / writeback stage around an external combinational ALU.
// S1 holds operands driven to the ALU, S2 holds the captured result for the consumer.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_imm_en,
    input  logic [BITS-1:0]   in_imm,
    output logic [BITS-1:0]   alu_a,
    output logic [BITS-1:0]   alu_b,
    output logic [2:0]        alu_op,
    input  logic [BITS-1:0]   alu_result,
    input  logic [BITS-1:0]   alu_excess,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic [BITS-1:0]   out_result,
    output logic [BITS-1:0]   out_excess,
    output logic [FLAG_W-1:0] out_flags,
    output logic [BITS-1:0]   hi_q,
    output logic [FLAG_W-1:0] flags_q,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [BITS-1:0]   dbg_data
);

    // S1: operands in front of the ALU
    logic              r_s1_valid;
    OperationType      r_s1_op;
    logic [REG_AW-1:0] r_s1_rd;
    logic [BITS-1:0]   r_s1_a;
    logic [BITS-1:0]   r_s1_b;

    // S2: captured ALU outputs
    logic              r_s2_valid;
    logic [REG_AW-1:0] r_s2_rd;
    logic [BITS-1:0]   r_s2_result;
    logic [BITS-1:0]   r_s2_excess;
    logic [FLAG_W-1:0] r_s2_flags;

    logic [BITS-1:0]   r_hi;
    logic [FLAG_W-1:0] r_flags;

    logic              w_s1_go;
    logic              w_accept;
    logic [BITS-1:0]   w_rs1_data;
    logic [BITS-1:0]   w_rs2_data;

    // S1 advances whenever S2 is empty or being drained this cycle
    assign w_s1_go  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_go;
    assign w_accept = in_valid && in_ready;

    // Writeback port doubles as the bypass source for the next instruction's operands
    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_s1_go),
        .i_waddr    (r_s1_rd),
        .i_wdata    (alu_result),
        .i_raddr_a  (in_rs1),
        .o_rdata_a  (w_rs1_data),
        .i_raddr_b  (in_rs2),
        .o_rdata_b  (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // S1 register: load on accept, empty when it advances with nothing new behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OpAdd;
            r_s1_rd    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= OperationType'(in_op);
            r_s1_rd    <= in_rd;
            r_s1_a     <= w_rs1_data;
            r_s1_b     <= in_imm_en ? in_imm : w_rs2_data;
        end else if (w_s1_go) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 register plus architectural HI/flags: all update on S1 advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_rd     <= '0;
            r_s2_result <= '0;
            r_s2_excess <= '0;
            r_s2_flags  <= '0;
            r_hi        <= '0;
            r_flags     <= '0;
        end else if (w_s1_go) begin
            r_s2_valid  <= 1'b1;
            r_s2_rd     <= r_s1_rd;
            r_s2_result <= alu_result;
            r_s2_excess <= alu_excess;
            r_s2_flags  <= alu_flags;
            r_flags     <= alu_flags;
            if (op_writes_hi(r_s1_op)) begin
                r_hi <= alu_excess;
            end
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign alu_a      = r_s1_a;
    assign alu_b      = r_s1_b;
    assign alu_op     = r_s1_op;
    assign out_valid  = r_s2_valid;
    assign out_rd     = r_s2_rd;
    assign out_result = r_s2_result;
    assign out_excess = r_s2_excess;
    assign out_flags  = r_s2_flags;
    assign hi_q       = r_hi;
    assign flags_q    = r_flags;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic [15:0] alu_excess;
    logic [4:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_rd;
    logic [15:0] out_result;
    logic [15:0] out_excess;
    logic [4:0]  out_flags;
    logic [15:0] hi_q;
    logic [4:0]  flags_q;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp;
    int n_bad;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_excess (alu_excess),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_excess (out_excess),
        .out_flags  (out_flags),
        .hi_q       (hi_q),
        .flags_q    (flags_q),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags packed {V,C,N,P,Z}; SUB carry means borrow
    logic [31:0] m_wide;
    logic [16:0] m_sum;
    logic        m_c;
    logic        m_v;
    always_comb begin
        m_wide     = '0;
        m_sum      = '0;
        m_c        = 1'b0;
        m_v        = 1'b0;
        alu_result = '0;
        alu_excess = '0;
        case (alu_op)
            3'd0: begin
                m_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = m_sum[15:0];
                m_c        = m_sum[16];
                alu_excess = {15'd0, m_c};
                m_v        = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            3'd1: begin
                m_sum      = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = m_sum[15:0];
                m_c        = m_sum[16];
                alu_excess = {15'd0, m_c};
                m_v        = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            3'd2: begin
                m_wide     = {16'd0, alu_a} * {16'd0, alu_b};
                alu_result = m_wide[15:0];
                alu_excess = m_wide[31:16];
                m_c        = |m_wide[31:16];
            end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: begin
                m_wide     = {16'd0, alu_a} << alu_b[3:0];
                alu_result = m_wide[15:0];
                alu_excess = m_wide[31:16];
            end
            default: begin
                m_wide     = {16'd0, alu_a} << alu_b[3:0];
                alu_result = m_wide[15:0] | m_wide[31:16];
            end
        endcase
        alu_flags = {m_v, m_c, alu_result[15], ^alu_result, alu_result == 16'd0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm_en = imm_en;
        in_imm    = imm;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm_en = 1'b0;
        in_imm    = '0;
        out_ready = 1'b1;
        dbg_addr  = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", flags_q, 0);
        check("rst_hi", hi_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back dependent ADDs resolved through the write-first bypass
        drive(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
        tick();
        check("dep_s1_a", alu_a, 16'd0);
        check("dep_s1_b", alu_b, 16'd5);
        drive(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0);
        check("dep_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("dep_bypass_a", alu_a, 16'd5);
        check("dep_bypass_b", alu_b, 16'd5);
        check("dep_out1_valid", out_valid, 1);
        check("dep_out1_rd", out_rd, 3'd1);
        check("dep_out1_result", out_result, 16'd5);
        tick();
        check("dep_out2_rd", out_rd, 3'd2);
        check("dep_out2_result", out_result, 16'd10);
        tick();
        check("dep_drained", out_valid, 0);
        check_reg("dep_r1", 3'd1, 16'd5);
        check_reg("dep_r2", 3'd2, 16'd10);

        // Reset pulse while idle clears every register
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("idle_rst_out_valid", out_valid, 0);
        check("idle_rst_in_ready", in_ready, 1);
        check("idle_rst_flags", flags_q, 0);
        for (int r = 0; r < 8; r++) begin
            check_reg($sformatf("idle_rst_r%0d", r), r[2:0], 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MUL: r4 = 0x1234, r3 = r4 * 0x0100
        drive(3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h1234);
        tick();
        drive(3'd2, 3'd3, 3'd4, 3'd0, 1'b1, 16'h0100);
        tick();
        in_valid = 1'b0;
        check("add_no_hi", hi_q, 16'h0000);
        tick();
        check("mul_result", out_result, 16'h3400);
        check("mul_excess", out_excess, 16'h0012);
        check("mul_hi", hi_q, 16'h0012);
        tick();
        check_reg("mul_r3", 3'd3, 16'h3400);

        // SUB into r0: result visible, flags updated, r0 and HI untouched
        drive(3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("sub_result", out_result, 16'hFFFF);
        check("sub_rd", out_rd, 3'd0);
        check("sub_flag_n", flags_q[2], 1);
        check("sub_flags", flags_q, 5'b01100);
        check("sub_hi_kept", hi_q, 16'h0012);
        check_reg("sub_r0", 3'd0, 16'd0);
        tick();

        // Backpressure: three offered, two accepted, S2 frozen until released
        out_ready = 1'b0;
        drive(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 16'd1);
        tick();
        drive(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'd2);
        check("bp_ready_2nd", in_ready, 1);
        tick();
        drive(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16'd3);
        check("bp_ready_3rd", in_ready, 0);
        check("bp_s2_rd", out_rd, 3'd5);
        tick();
        tick();
        check("bp_still_blocked", in_ready, 0);
        check("bp_s2_stable", out_result, 16'd1);
        check("bp_s1_held", alu_b, 16'd2);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_drain1", out_result, 16'd2);
        check("bp_drain1_rd", out_rd, 3'd6);
        tick();
        check("bp_drain2", out_result, 16'd3);
        check("bp_drain2_rd", out_rd, 3'd7);
        tick();
        check("bp_empty", out_valid, 0);
        check_reg("bp_r5", 3'd5, 16'd1);
        check_reg("bp_r6", 3'd6, 16'd2);
        check_reg("bp_r7", 3'd7, 16'd3);

        // Reset with S1 and S2 both occupied
        out_ready = 1'b0;
        drive(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd9);
        tick();
        drive(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd8);
        tick();
        in_valid = 1'b0;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check_reg("mid_rst_r2", 3'd2, 16'd0);
        check_reg("mid_rst_r1", 3'd1, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_idle", out_valid, 0);
        check_reg("post_rst_r2", 3'd2, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
